// File: rtl/cs_pkg.sv
// Shared types and Q3.13 constants for the
// compressed-sensing frame controller.
package cs_pkg;

  localparam int CS_DW   = 16;
  localparam int CS_FRAC = 13;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    DRAIN,
    FLUSH
  } cs_ctrl_state_t;

endpackage

// File: rtl/cs_sync_fifo.sv
// Synchronous first-word-fall-through FIFO
// with clear; head is valid whenever !empty.
module cs_sync_fifo #(
  parameter  int DW    = 16,
  parameter  int DEPTH = 16,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr, rd;

  function automatic logic [AW-1:0] nxt(
    input logic [AW-1:0] p
  );
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full  = cnt_q == CW'(DEPTH);
  assign empty = cnt_q == '0;
  assign count = cnt_q;
  assign dout  = mem_q[rd_q];
  assign rd    = pop & ~empty;
  assign wr    = push & (~full | rd);

  always_comb begin
    wr_d  = wr ? nxt(wr_q) : wr_q;
    rd_d  = rd ? nxt(rd_q) : rd_q;
    cnt_d = cnt_q + CW'(wr) - CW'(rd);
    if (clear) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr && !clear) begin
      mem_q[wr_q] <= din;
    end
  end

endmodule

// File: rtl/cs_frame_ctrl.sv
// Frame controller: feeds samples to the CS
// datapath, queues its results, streams them out.
module cs_frame_ctrl
  import cs_pkg::*;
#(
  parameter int N_SAMPLES = 64,
  parameter int M_MEAS    = 16,
  parameter int DW        = CS_DW,
  parameter int TIMEOUT   = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  output logic          s_ready,
  output logic          dp_en,
  output logic [DW-1:0] dp_d_in,
  input  logic [DW-1:0] dp_d_out,
  input  logic          dp_flag,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  input  logic          m_ready,
  output logic          busy,
  output logic          done,
  output logic          err_timeout
);

  localparam int SW = $clog2(N_SAMPLES + 1);
  localparam int RW = $clog2(M_MEAS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] S_LAST = SW'(N_SAMPLES - 1);
  localparam logic [RW-1:0] R_MAX  = RW'(M_MEAS);
  localparam logic [RW-1:0] R_LAST = RW'(M_MEAS - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  cs_ctrl_state_t state_q, state_d;
  logic [SW-1:0]  smp_cnt_q, smp_cnt_d;
  logic [RW-1:0]  res_cnt_q, res_cnt_d;
  logic [RW-1:0]  pop_cnt_q, pop_cnt_d;
  logic [TW-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic           err_q, err_d;
  logic           dp_en_q, dp_en_d;
  logic [DW-1:0]  dp_d_in_q, dp_d_in_d;
  logic           hs, push, pop, clr;
  logic           f_full, f_empty;
  logic [RW-1:0]  f_count;
  logic [DW-1:0]  f_head;

  assign s_ready     = state_q == FEED;
  assign hs          = s_valid & s_ready;
  assign push        = dp_flag
                     & ((state_q == FEED) | (state_q == DRAIN))
                     & (res_cnt_q != R_MAX) & ~f_full;
  assign m_valid     = f_count != '0;
  assign pop         = m_valid & m_ready;
  assign m_data      = m_valid ? f_head : '0;
  assign m_last      = m_valid & (pop_cnt_q == R_LAST);
  assign busy        = state_q != IDLE;
  assign done        = (state_q == FLUSH) & f_empty
                     & (pop_cnt_q == R_MAX);
  assign err_timeout = err_q;
  assign dp_en       = dp_en_q;
  assign dp_d_in     = dp_d_in_q;

  always_comb begin
    state_d   = state_q;
    smp_cnt_d = smp_cnt_q;
    res_cnt_d = res_cnt_q + RW'(push);
    pop_cnt_d = pop_cnt_q + RW'(pop);
    tmo_cnt_d = tmo_cnt_q;
    err_d     = err_q;
    clr       = 1'b0;
    dp_en_d   = hs;
    dp_d_in_d = hs ? s_data : dp_d_in_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = FEED;
          smp_cnt_d = '0;
          res_cnt_d = '0;
          pop_cnt_d = '0;
          tmo_cnt_d = '0;
          err_d     = 1'b0;
        end
      end
      FEED: begin
        if (hs) begin
          smp_cnt_d = smp_cnt_q + SW'(1);
          if (smp_cnt_q == S_LAST) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        tmo_cnt_d = dp_flag ? '0 : tmo_cnt_q + TW'(1);
        // A completed result set wins over a timeout
        if (res_cnt_d == R_MAX) begin
          state_d = FLUSH;
        end else if (!dp_flag && tmo_cnt_q == T_LAST) begin
          err_d   = 1'b1;
          clr     = 1'b1;
          state_d = IDLE;
        end
      end
      FLUSH: begin
        if (done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      smp_cnt_q <= '0;
      res_cnt_q <= '0;
      pop_cnt_q <= '0;
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
      dp_en_q   <= 1'b0;
      dp_d_in_q <= '0;
    end else begin
      state_q   <= state_d;
      smp_cnt_q <= smp_cnt_d;
      res_cnt_q <= res_cnt_d;
      pop_cnt_q <= pop_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
      err_q     <= err_d;
      dp_en_q   <= dp_en_d;
      dp_d_in_q <= dp_d_in_d;
    end
  end

  cs_sync_fifo #(
    .DW   (DW),
    .DEPTH(M_MEAS)
  ) u_res_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .clear(clr),
    .din  (dp_d_out),
    .dout (f_head),
    .full (f_full),
    .empty(f_empty),
    .count(f_count)
  );

endmodule

// File: tb/tb_cs_frame_ctrl.sv
// Scoreboard bench for cs_frame_ctrl: directed
// frames plus randomized traffic against a model.
module tb_cs_frame_ctrl;

  localparam int N = 4;
  localparam int M = 2;
  localparam int T = 8;
  localparam int P_IDLE  = 0;
  localparam int P_FEED  = 1;
  localparam int P_DRAIN = 2;
  localparam int P_FLUSH = 3;

  logic        clk = 1'b0;
  logic        rst, start, s_valid, dp_flag, m_ready;
  logic [15:0] s_data, dp_d_out;
  logic        s_ready, dp_en, m_valid, m_last;
  logic        busy, done, err_timeout;
  logic [15:0] dp_d_in, m_data;

  int n_cmp = 0;
  int n_err = 0;
  bit armed = 0;

  int ph = P_IDLE;
  int fed, res, pops, quiet, occ;
  bit err, exp_dp_en;
  logic [15:0] dq[$];
  logic [15:0] mq[$];

  always #5 clk = ~clk;

  cs_frame_ctrl #(
    .N_SAMPLES(N),
    .M_MEAS   (M),
    .DW       (16),
    .TIMEOUT  (T)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .dp_en      (dp_en),
    .dp_d_in    (dp_d_in),
    .dp_d_out   (dp_d_out),
    .dp_flag    (dp_flag),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_last     (m_last),
    .m_ready    (m_ready),
    .busy       (busy),
    .done       (done),
    .err_timeout(err_timeout)
  );

  function automatic void chk(string name,
                              logic [31:0] act,
                              logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h",
               name, act, exp);
    end
  endfunction

  function automatic void underflow(string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: output beat with empty queue",
             name);
  endfunction

  // Behavioural frame model, advanced at each edge
  task automatic model_update();
    bit hs, cap, pop, fin;
    if (rst) begin
      ph = P_IDLE;
      fed = 0; res = 0; pops = 0;
      quiet = 0; occ = 0;
      err = 0; exp_dp_en = 0;
      dq.delete();
      mq.delete();
      return;
    end
    hs  = (ph == P_FEED) && s_valid;
    cap = (ph == P_FEED || ph == P_DRAIN)
          && dp_flag && res < M;
    pop = occ > 0 && m_ready;
    fin = ph == P_FLUSH && occ == 0 && pops == M;
    exp_dp_en = hs;
    if (hs) dq.push_back(s_data);
    if (cap) begin
      mq.push_back(dp_d_out);
      res++;
      occ++;
    end
    if (pop) begin
      occ--;
      pops++;
    end
    case (ph)
      P_IDLE: begin
        if (start) begin
          ph = P_FEED;
          fed = 0; res = 0; pops = 0;
          quiet = 0; err = 0;
        end
      end
      P_FEED: begin
        if (hs) fed++;
        if (fed == N) ph = P_DRAIN;
      end
      P_DRAIN: begin
        quiet = dp_flag ? 0 : quiet + 1;
        if (res == M) ph = P_FLUSH;
        else if (quiet == T) begin
          err = 1;
          ph = P_IDLE;
          occ = 0;
          mq.delete();
        end
      end
      P_FLUSH: if (fin) ph = P_IDLE;
      default: ;
    endcase
  endtask

  always @(negedge clk) begin
    if (armed) begin
      chk("s_ready", 32'(s_ready), 32'(ph == P_FEED));
      chk("busy", 32'(busy), 32'(ph != P_IDLE));
      chk("done", 32'(done),
          32'(ph == P_FLUSH && occ == 0 && pops == M));
      chk("err_timeout", 32'(err_timeout), 32'(err));
      chk("dp_en", 32'(dp_en), 32'(exp_dp_en));
      if (dp_en) begin
        if (dq.size() == 0) underflow("dp_d_in");
        else chk("dp_d_in", 32'(dp_d_in),
                 32'(dq.pop_front()));
      end
      chk("m_valid", 32'(m_valid), 32'(occ > 0));
      if (m_valid) begin
        if (mq.size() == 0) underflow("m_data");
        else begin
          chk("m_data", 32'(m_data), 32'(mq[0]));
          chk("m_last", 32'(m_last),
              32'(pops == M - 1));
          if (m_ready) void'(mq.pop_front());
        end
      end else begin
        chk("m_last_idle", 32'(m_last), 32'(0));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic quiet_in();
    start = 0;
    s_valid = 0;
    dp_flag = 0;
  endtask

  task automatic pulse_start();
    start = 1;
    cyc();
    start = 0;
  endtask

  task automatic feed(int n, bit toggle);
    for (int i = 0; i < n; i++) begin
      s_valid = toggle ? ((i % 2) == 0) : 1'b1;
      s_data = 16'($urandom);
      cyc();
    end
    s_valid = 0;
  endtask

  task automatic flag(logic [15:0] v);
    dp_flag = 1;
    dp_d_out = v;
    cyc();
    dp_flag = 0;
  endtask

  logic [15:0] smp [4];

  initial begin
    smp = '{16'h0440, 16'h0880, 16'h1000, 16'h2000};
    rst = 1;
    start = 0; s_valid = 0; s_data = 0;
    dp_flag = 0; dp_d_out = 0; m_ready = 1;
    cyc();
    armed = 1;
    cyc();
    rst = 0;
    chk("rst_dp_d_in", 32'(dp_d_in), 32'(0));
    chk("rst_m_data", 32'(m_data), 32'(0));
    cyc();

    // nominal frame
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      s_valid = 1;
      s_data = smp[i];
      cyc();
    end
    s_valid = 0;
    flag(16'h0123);
    cyc();
    flag(16'h0456);
    repeat (6) cyc();

    // output backpressure
    m_ready = 0;
    pulse_start();
    feed(4, 0);
    flag(16'h0123);
    flag(16'h0456);
    repeat (4) cyc();
    m_ready = 1;
    repeat (6) cyc();

    // input stall
    pulse_start();
    feed(8, 1);
    flag(16'h1111);
    flag(16'h2222);
    repeat (6) cyc();

    // timeout, then a start clears the error
    pulse_start();
    feed(4, 0);
    flag(16'h0abc);
    repeat (12) cyc();
    pulse_start();
    feed(4, 0);
    flag(16'h3333);
    flag(16'h4444);
    repeat (6) cyc();

    // spurious flags and starts
    flag(16'hdead);
    pulse_start();
    feed(2, 0);
    pulse_start();
    feed(2, 0);
    flag(16'h5555);
    flag(16'h6666);
    flag(16'h7777);
    repeat (8) cyc();

    // reset mid-frame
    m_ready = 0;
    pulse_start();
    feed(2, 0);
    flag(16'h0bad);
    cyc();
    rst = 1;
    cyc();
    rst = 0;
    chk("mid_rst_m_valid", 32'(m_valid), 32'(0));
    chk("mid_rst_dp_d_in", 32'(dp_d_in), 32'(0));
    chk("mid_rst_m_data", 32'(m_data), 32'(0));
    m_ready = 1;
    pulse_start();
    feed(4, 0);
    flag(16'h0123);
    flag(16'h0456);
    repeat (6) cyc();

    // randomized traffic
    repeat (3000) begin
      rst = ($urandom_range(0, 999) == 0);
      start = ($urandom_range(0, 7) == 0);
      s_valid = 1'($urandom_range(0, 1));
      s_data = 16'($urandom);
      dp_flag = ($urandom_range(0, 4) == 0);
      dp_d_out = 16'($urandom);
      m_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    rst = 0;
    quiet_in();
    m_ready = 1;
    repeat (20) cyc();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cs_frame_ctrl.md
# cs_frame_ctrl

Frame-level controller for the compressed-sensing measurement datapath `d_in_verilog`, which has ports clk, rst, en, d_in[15:0], d_out[15:0] and flag_out. It accepts one frame of N_SAMPLES Q3.13 input samples over a valid/ready stream and forwards each one to the datapath as a registered en/d_in beat. It then collects M_MEAS measurement results flagged by flag_out in a result FIFO. Finally it returns them on an output valid/ready stream, marking the frame end, and reports completion or a timeout.

## Interface

Parameters:
- N_SAMPLES, 64: input samples per frame (≥2).
- M_MEAS, 16: measurements expected per frame; also the result FIFO depth (≥2).
- DW, 16: sample/measurement width, Q3.13 (unsigned, 13 fractional bits).
- TIMEOUT, 255: maximum idle cycles between results before abort (≥1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a frame; ignored while busy.
- s_valid  in  1  input sample valid.
- s_data  in  DW  input sample, Q3.13.
- s_ready  out  1  controller accepts a sample.
- dp_en  out  1  datapath enable (drives en).
- dp_d_in  out  DW  datapath sample (drives d_in).
- dp_d_out  in  DW  datapath result (from d_out).
- dp_flag  in  1  datapath result-valid pulse (from flag_out).
- m_valid  out  1  measurement valid.
- m_data  out  DW  measurement, Q3.13.
- m_last  out  1  marks the M_MEAS-th measurement of the frame.
- m_ready  in  1  downstream accepts the measurement.
- busy  out  1  high in every state other than IDLE.
- done  out  1  one-cycle pulse at normal frame completion.
- err_timeout  out  1  sticky timeout flag; cleared by the next accepted start or by rst.

## Operation

- States: IDLE, FEED, DRAIN, FLUSH.
- IDLE → FEED on start; clears the sample count, result count, timeout counter and err_timeout.
- FEED:
  - s_ready=1; each s_valid&s_ready handshake increments the sample count.
  - The registered stage sets dp_en=1 and dp_d_in=s_data on the next cycle; otherwise dp_en=0 and dp_d_in holds its value.
  - Moves to DRAIN on the cycle the N_SAMPLES-th handshake occurs.
- Result capture runs in FEED and DRAIN:
  - dp_flag=1 with result count < M_MEAS pushes dp_d_out into the FIFO and increments the result count.
  - dp_flag in IDLE or FLUSH, or beyond M_MEAS results, is dropped.
- DRAIN:
  - s_ready=0.
  - The timeout counter increments every cycle without dp_flag and resets to 0 on dp_flag.
  - result count == M_MEAS → FLUSH.
  - Timeout counter reaching TIMEOUT → set err_timeout, clear the FIFO, go to IDLE; done is not asserted.
- FLUSH: wait for the FIFO to be empty and the final beat to be accepted, then pulse done and go to IDLE.
- Output stream:
  - m_valid = FIFO non-empty; m_data = FIFO head.
  - Pop on m_valid&m_ready.
  - m_data must hold stable while m_valid=1 and m_ready=0.
  - m_last=1 on the beat whose pop index within the frame equals M_MEAS-1.
- The FIFO cannot overflow, because at most M_MEAS pushes occur per frame. A push and a pop in the same cycle leaves the occupancy unchanged.
- A start received in FEED, DRAIN or FLUSH is ignored.
- No arithmetic is performed on the data; widths pass through at DW.

## Timing

- Reset values: s_ready=0, dp_en=0, dp_d_in=0, m_valid=0, m_data=0, m_last=0, busy=0, done=0, err_timeout=0. State is IDLE and the FIFO is empty.
- rst mid-frame aborts immediately: the next cycle matches the reset values above and the FIFO contents are discarded.
- start in cycle t → busy=1 and s_ready=1 in cycle t+1.
- Handshake in cycle t → dp_en=1 in cycle t+1, a one-cycle latency. Back-to-back handshakes produce consecutive dp_en cycles.
- dp_flag in cycle t → m_valid=1 in cycle t+1 if the FIFO was empty; the FIFO read is first-word-fall-through.
- Last pop in cycle t → done=1 and busy=1 in cycle t+1, then busy=0 in cycle t+2.
- Timeout: TIMEOUT consecutive cycles without dp_flag in DRAIN → err_timeout=1 and busy=0 on the following cycle.

## Structure

- Shared package `cs_pkg`:
  - Q3.13 constants: CS_DW=16, CS_FRAC=13.
  - State enum cs_ctrl_state_t with IDLE/FEED/DRAIN/FLUSH.
- Sub-module `cs_sync_fifo`:
  - Parameters DW and DEPTH; synchronous reset; first-word-fall-through.
  - Ports: push, pop, clear, full, empty, count.
  - Instantiated once for the result FIFO.
- The top level holds the FSM, the sample, result, pop and timeout counters, and the dp_en/dp_d_in register.

## Test plan

1. Nominal frame (N=4, M=2, m_ready=1): start, then samples 0x0440, 0x0880, 0x1000, 0x2000 → dp_en high for 4 cycles with those values, each one cycle late. dp_flag with 0x0123 and 0x0456 → m_data 0x0123 then 0x0456 (m_last on the second), done pulse, busy falls.
2. Output backpressure: m_ready=0 during both results → m_valid held with m_data=0x0123 stable. Raising m_ready drains 0x0123 then 0x0456 in order; done follows the last pop.
3. Input stall: s_valid toggles 1,0,1,0 → dp_en pattern 0,1,0,1 offset by one cycle; the sample count reaches N only after 4 handshakes.
4. Timeout (TIMEOUT=8): full frame fed, one dp_flag only → err_timeout=1 on the cycle after the 8th quiet cycle, no done, FIFO empty. A subsequent start clears err_timeout.
5. Spurious events: dp_flag in IDLE and a third dp_flag with M=2 → no FIFO push. A start during FEED → sample count unaffected.
6. Reset mid-frame: rst after 2 of 4 samples with 1 result queued → all outputs at reset values next cycle, m_valid=0; a fresh frame then completes normally.
